// File: rtl/fft_frame_feeder.sv
// Frames a free-running real sample stream into AXI-Stream beats for the FFT core,
// with a small skid FIFO, a frame counter driving tlast, and config-channel sequencing.
module fft_frame_feeder #(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned NFFT_LOG2  = 10,
    parameter int unsigned FIFO_AW    = 4,
    parameter logic [15:0] CFG_WORD   = 16'h0A01,
    parameter bit          OFFSET_BIN = 1'b0
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              cfg_req,
    output logic [15:0]       s_axis_config_tdata,
    output logic              s_axis_config_tvalid,
    input  logic              s_axis_config_tready,
    output logic [31:0]       s_axis_data_tdata,
    output logic              s_axis_data_tvalid,
    input  logic              s_axis_data_tready,
    output logic              s_axis_data_tlast,
    output logic              overflow,
    output logic              busy_cfg
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE_CFG, CFG, RUN, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [FIFO_AW:0]     wr_ptr, rd_ptr;
    logic [15:0]          mem [DEPTH];
    logic [NFFT_LOG2-1:0] beat_cnt, load_idx;
    logic [15:0]          d_real;
    logic                 cfg_valid, d_valid, d_last, ovf;
    logic                 fifo_empty, fifo_full, hs, frame_done, out_free, frame_idle;
    logic                 fifo_rd, pad_ld, load, fifo_wr, drop, cfg_hs, drain_exit;

    function automatic logic [15:0] to_real(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = x;
        r[DATA_W-1] = r[DATA_W-1] ^ OFFSET_BIN;
        return 16'($signed(r));
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    assign hs         = d_valid & s_axis_data_tready;
    assign frame_done = hs & d_last;
    assign out_free   = ~d_valid | hs;
    // Nothing of the current frame has been loaded yet, so a drain has nothing to finish.
    assign frame_idle = ~d_valid & (beat_cnt == '0) & fifo_empty;
    assign load_idx   = beat_cnt + NFFT_LOG2'(hs);

    assign fifo_rd = out_free & ~fifo_empty &
                     ((state == RUN) | ((state == DRAIN) & ~frame_done));
    // Input is closed while draining, so a frame that runs out of samples is completed with zeros.
    assign pad_ld  = (state == DRAIN) & out_free & fifo_empty & ~frame_done & ~frame_idle;
    assign load    = fifo_rd | pad_ld;

    assign fifo_wr    = data_in_valid & (state == RUN) & (~fifo_full | fifo_rd);
    assign drop       = data_in_valid & (state == RUN) & fifo_full & ~fifo_rd;
    assign cfg_hs     = cfg_valid & s_axis_config_tready;
    assign drain_exit = (state == DRAIN) & (frame_done | frame_idle);

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            CFG:     if (cfg_hs)     state_nxt = RUN;
            RUN:     if (cfg_req)    state_nxt = DRAIN;
            DRAIN:   if (drain_exit) state_nxt = CFG;
            default:                 state_nxt = CFG;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= CFG;
            cfg_valid <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf       <= 1'b0;
            d_valid   <= 1'b0;
            d_last    <= 1'b0;
            d_real    <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cfg_valid <= (state == CFG) & ~cfg_hs;
            if (drop)
                ovf <= 1'b1;
            if (drain_exit) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
                if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            end
            if (load) begin
                d_valid <= 1'b1;
                d_real  <= fifo_rd ? mem[rd_ptr[FIFO_AW-1:0]] : 16'd0;
                d_last  <= &load_idx;
            end else if (hs) begin
                d_valid <= 1'b0;
            end
            if (drain_exit)
                beat_cnt <= '0;
            else if (hs)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge sclk) begin
        if (fifo_wr)
            mem[wr_ptr[FIFO_AW-1:0]] <= to_real(data_in);
    end

    assign s_axis_config_tdata  = CFG_WORD;
    assign s_axis_config_tvalid = cfg_valid;
    assign s_axis_data_tdata    = {16'd0, d_real};
    assign s_axis_data_tvalid   = d_valid;
    assign s_axis_data_tlast    = d_last;
    assign overflow             = ovf;
    assign busy_cfg             = (state == CFG);

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: two instances (two's complement and offset-binary)
// share stimulus; expected beats are queued at issue time and popped by a monitor.
`timescale 1ns/1ps
module tb_fft_frame_feeder;

    localparam int FRAME = 8;
    localparam int DEPTH = 4;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic [13:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_tready = 1'b0;
    logic        d_tready = 1'b0;

    logic [15:0] cfg_tdata0, cfg_tdata1;
    logic        cfg_tvalid0, cfg_tvalid1;
    logic [31:0] d_tdata0, d_tdata1;
    logic        d_tvalid0, d_tvalid1, d_tlast0, d_tlast1;
    logic        ovf0, ovf1, busy0, busy1;

    always #5 sclk = ~sclk;

    fft_frame_feeder #(.DATA_W(14), .NFFT_LOG2(3), .FIFO_AW(2), .CFG_WORD(16'h0A01), .OFFSET_BIN(1'b0)) dut_bin (
        .sclk(sclk), .s_rst_n(s_rst_n), .data_in(data_in), .data_in_valid(data_in_valid), .cfg_req(cfg_req),
        .s_axis_config_tdata(cfg_tdata0), .s_axis_config_tvalid(cfg_tvalid0), .s_axis_config_tready(cfg_tready),
        .s_axis_data_tdata(d_tdata0), .s_axis_data_tvalid(d_tvalid0), .s_axis_data_tready(d_tready),
        .s_axis_data_tlast(d_tlast0), .overflow(ovf0), .busy_cfg(busy0));

    fft_frame_feeder #(.DATA_W(14), .NFFT_LOG2(3), .FIFO_AW(2), .CFG_WORD(16'h0A01), .OFFSET_BIN(1'b1)) dut_ofs (
        .sclk(sclk), .s_rst_n(s_rst_n), .data_in(data_in), .data_in_valid(data_in_valid), .cfg_req(cfg_req),
        .s_axis_config_tdata(cfg_tdata1), .s_axis_config_tvalid(cfg_tvalid1), .s_axis_config_tready(cfg_tready),
        .s_axis_data_tdata(d_tdata1), .s_axis_data_tvalid(d_tvalid1), .s_axis_data_tready(d_tready),
        .s_axis_data_tlast(d_tlast1), .overflow(ovf1), .busy_cfg(busy1));

    typedef struct {
        logic [13:0] raw;
        bit          pad;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0, errors = 0;
    int          pushed = 0, popped = 0, pos = 0;
    int          cfg_hs = 0, cfg_vcycles = 0;
    bit          stall = 0;
    logic [31:0] held_data;
    logic        held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Real part as the core should see it: two's complement value in 16 bits.
    function automatic logic [15:0] ref_real(input logic [13:0] raw, input bit ob);
        int v;
        v = int'(raw);
        if (ob) v = (v + 8192) % 16384;
        if (v >= 8192) v = v - 16384;
        return 16'(v);
    endfunction

    function automatic logic [31:0] exp_data(input beat_t b, input bit ob);
        return b.pad ? 32'd0 : {16'd0, ref_real(b.raw, ob)};
    endfunction

    task automatic push_sample(input logic [13:0] raw);
        beat_t b;
        b.raw = raw; b.pad = 1'b0; b.last = (pos == FRAME - 1);
        exp_q.push_back(b);
        pos = (pos + 1) % FRAME;
        pushed++;
    endtask

    task automatic pad_frame();
        beat_t b;
        while (pos != 0) begin
            b.raw = '0; b.pad = 1'b1; b.last = (pos == FRAME - 1);
            exp_q.push_back(b);
            pos = (pos + 1) % FRAME;
            pushed++;
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_busy(input logic level, input string name);
        int n = 0;
        while (busy0 !== level && n < 200) begin
            tick();
            n++;
        end
        check(name, busy0, level);
    endtask

    // Monitor: config channel accounting, AXI hold rule, and scoreboard pops on data handshakes.
    always @(negedge sclk) begin
        if (!s_rst_n) begin
            stall = 0;
        end else begin
            if (stall) begin
                check("hold_valid", d_tvalid0, 1'b1);
                check("hold_data", d_tdata0, held_data);
                check("hold_last", d_tlast0, held_last);
            end
            if (cfg_tvalid0) begin
                cfg_vcycles++;
                check("cfg_tdata", cfg_tdata0, 16'h0A01);
                if (cfg_tready) cfg_hs++;
            end
            if (d_tvalid0 && d_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata %0h with no expected beat at %0t", d_tdata0, $time);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    popped++;
                    check("beat_tdata_bin", d_tdata0, exp_data(b, 1'b0));
                    check("beat_tdata_ofs", d_tdata1, exp_data(b, 1'b1));
                    check("beat_tlast", d_tlast0, b.last);
                    check("beat_tlast_ofs", d_tlast1, b.last);
                end
            end
            stall     = d_tvalid0 && !d_tready;
            held_data = d_tdata0;
            held_last = d_tlast0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] first;
        int          hs0, n;

        repeat (3) @(posedge sclk);
        #1;
        check("rst_cfg_tvalid", cfg_tvalid0, 1'b0);
        check("rst_d_tvalid", d_tvalid0, 1'b0);
        check("rst_d_tlast", d_tlast0, 1'b0);
        check("rst_d_tdata", d_tdata0, 32'd0);
        check("rst_overflow", ovf0, 1'b0);
        check("rst_busy", busy0, 1'b1);

        // Config held 5 valid cycles with tready low, accepted on the 6th.
        @(negedge sclk);
        s_rst_n = 1'b1;
        cfg_vcycles = 0;
        cfg_hs = 0;
        repeat (6) tick();
        cfg_tready = 1'b1;
        tick();
        tick();
        check("cfg_valid_cycles", cfg_vcycles, 6);
        check("cfg_handshakes", cfg_hs, 1);
        check("cfg_run", busy0, 1'b0);

        // Continuous ramp, tlast on 7, 15, 23, first tvalid two cycles after the write.
        d_tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    data_in = 14'(i);
                    data_in_valid = 1'b1;
                    push_sample(14'(i));
                    tick();
                end
                data_in_valid = 1'b0;
            end
            begin
                @(negedge sclk);
                @(negedge sclk);
                check("latency_n_plus_1", d_tvalid0, 1'b0);
                @(negedge sclk);
                check("latency_n_plus_2", d_tvalid0, 1'b1);
            end
        join
        wait_drain("ramp_drained");

        // Most negative two's complement vs mid-scale offset binary.
        data_in = 14'h2000;
        data_in_valid = 1'b1;
        push_sample(14'h2000);
        tick();
        data_in_valid = 1'b0;
        tick();
        check("conv_valid", d_tvalid0, 1'b1);
        check("conv_twos", d_tdata0, 32'h0000E000);
        check("conv_offset", d_tdata1, 32'h00000000);
        wait_drain("conv_drained");

        // Stall: 4 FIFO words plus the output register survive, the rest are dropped.
        d_tready = 1'b0;
        first = 14'($urandom);
        for (int i = 0; i < 10; i++) begin
            data_in = (i == 0) ? first : 14'($urandom);
            data_in_valid = 1'b1;
            if (i < DEPTH + 1) push_sample(data_in);
            tick();
        end
        data_in_valid = 1'b0;
        tick();
        tick();
        check("ovf_set", ovf0, 1'b1);
        check("ovf_set_ofs", ovf1, 1'b1);
        check("stall_valid", d_tvalid0, 1'b1);
        check("stall_head", d_tdata0, {16'd0, ref_real(first, 1'b0)});
        d_tready = 1'b1;
        wait_drain("stall_drained");
        check("ovf_sticky", ovf0, 1'b1);

        // Random backpressure with input throttled to what the FIFO can hold.
        for (int i = 0; i < 400; i++) begin
            d_tready = ($urandom_range(0, 3) != 0);
            if ((pushed - popped) < DEPTH && $urandom_range(0, 9) < 7) begin
                data_in = 14'($urandom);
                data_in_valid = 1'b1;
                push_sample(data_in);
            end else begin
                data_in_valid = 1'b0;
            end
            tick();
        end
        data_in_valid = 1'b0;
        d_tready = 1'b1;
        wait_drain("random_drained");

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) begin
            data_in = 14'($urandom);
            data_in_valid = 1'b1;
            push_sample(data_in);
            tick();
        end
        @(posedge sclk);
        #2;
        s_rst_n = 1'b0;
        data_in_valid = 1'b0;
        #1;
        check("async_d_tvalid", d_tvalid0, 1'b0);
        check("async_d_tdata", d_tdata0, 32'd0);
        check("async_d_tlast", d_tlast0, 1'b0);
        check("async_cfg_tvalid", cfg_tvalid0, 1'b0);
        check("async_overflow", ovf0, 1'b0);
        check("async_busy", busy0, 1'b1);
        exp_q.delete();
        pos = 0;
        pushed = 0;
        popped = 0;
        @(negedge sclk);
        @(negedge sclk);
        hs0 = cfg_hs;
        s_rst_n = 1'b1;
        wait_busy(1'b0, "reconfig_run");
        check("reconfig_handshakes", cfg_hs, hs0 + 1);

        // cfg_req after beat 3: the frame completes (zero-filled), then a fresh config.
        n = 0;
        while (popped < 4 && n < 100) begin
            data_in = 14'($urandom);
            data_in_valid = 1'b1;
            push_sample(data_in);
            tick();
            n++;
        end
        check("drain_start", popped >= 4, 1'b1);
        cfg_tready = 1'b0;
        cfg_req = 1'b1;
        data_in_valid = 1'b0;
        pad_frame();
        tick();
        cfg_req = 1'b0;
        data_in = 14'h1234;
        data_in_valid = 1'b1;
        tick();
        tick();
        data_in_valid = 1'b0;
        hs0 = cfg_hs;
        wait_busy(1'b1, "drain_to_cfg");
        tick();
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        tick();
        cfg_tready = 1'b1;
        wait_busy(1'b0, "drain_cfg_run");
        check("drain_cfg_handshakes", cfg_hs, hs0 + 1);
        wait_drain("drain_frame_done");
        for (int i = 0; i < FRAME; i++) begin
            data_in = 14'($urandom);
            data_in_valid = 1'b1;
            push_sample(data_in);
            tick();
        end
        data_in_valid = 1'b0;
        wait_drain("fresh_frame_drained");
        tick();
        check("fresh_frame_no_extra_cfg", cfg_hs, hs0 + 1);
        check("no_ovf_after_drain", ovf0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Upstream stage of the FFT core. Converts the free-running 14-bit sample stream into framed AXI-Stream input for the core.
- Drives the core's config channel once after reset and again on request.
- Buffers samples through a small FIFO so that core backpressure (s_axis_data_tready low) does not corrupt frames.
- Asserts s_axis_data_tlast on every NFFT-th output beat.

Parameters:
- DATA_W, 14: width of data_in.
- NFFT_LOG2, 10: log2 of transform length; frame = 2^NFFT_LOG2 beats.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW entries.
- CFG_WORD, 16'h0A01: value driven on s_axis_config_tdata.
- OFFSET_BIN, 0: 1 = data_in is offset-binary, so invert the MSB before sign extension.

Ports:
- sclk  in  1  system clock, all logic on rising edge
- s_rst_n  in  1  asynchronous active-low reset
- data_in  in  DATA_W  real sample
- data_in_valid  in  1  sample qualifier
- cfg_req  in  1  single-cycle request to re-send config
- s_axis_config_tdata  out  16  config word to the core (constant CFG_WORD)
- s_axis_config_tvalid  out  1  config valid
- s_axis_config_tready  in  1  core accepts config
- s_axis_data_tdata  out  32  {16'd0 imag, sign-extended real[15:0]}
- s_axis_data_tvalid  out  1  data valid
- s_axis_data_tready  in  1  core accepts data
- s_axis_data_tlast  out  1  last beat of frame
- overflow  out  1  sticky: sample dropped because FIFO was full
- busy_cfg  out  1  high while in CFG state

Behaviour:
- Reset: the asynchronous assertion of s_rst_n clears the following.
  - s_axis_config_tvalid=0, s_axis_data_tvalid=0, s_axis_data_tlast=0, s_axis_data_tdata=0.
  - overflow=0, busy_cfg=1, FIFO empty, beat counter=0.
  - FSM state = CFG.
- FSM states IDLE_CFG, CFG, RUN, DRAIN.
  - CFG: s_axis_config_tvalid=1 and held until s_axis_config_tready=1 on a clock edge, then RUN next cycle. tdata stays stable throughout.
  - RUN: normal streaming.
  - cfg_req pulse in RUN: latch a pending flag, then go to DRAIN.
  - DRAIN: stop writing FIFO; keep emitting beats until the current frame's tlast beat completes (tvalid&tready&tlast). Then flush the FIFO, reset the beat counter, and enter CFG.
  - cfg_req while in CFG or DRAIN: ignored.
- Input side:
  - A sample is written when data_in_valid=1, state=RUN and the FIFO is not full.
  - If data_in_valid=1, state=RUN and the FIFO is full: drop the sample and set overflow (sticky until reset).
  - Samples in CFG or DRAIN are discarded without setting overflow.
- Conversion at write:
  - real = data_in, with the MSB inverted if OFFSET_BIN=1.
  - The result is sign-extended to 16 bits; the imaginary half is 0.
- Output side (AXI rules):
  - tdata and tlast are registered.
  - Once tvalid=1, tvalid/tdata/tlast are held until tready=1; tvalid never drops without a handshake.
  - The output register reloads from the FIFO when it is empty or being handshaken in the same cycle.
  - Back-to-back beats are sustained at 1/clk.
- Latency: a sample written into an empty FIFO in cycle N is presented with tvalid=1 in cycle N+2.
- Frame counter:
  - Width NFFT_LOG2; it increments on each handshake (tvalid&tready).
  - tlast=1 on the beat loaded while count = 2^NFFT_LOG2-1.
  - The counter wraps to 0 after the tlast handshake.
- FIFO:
  - Pointers are FIFO_AW+1 bits; full/empty are decided by the MSB compare.
  - Simultaneous read and write when full is allowed: the read frees a slot, and the write succeeds with no overflow.
- Reset mid-frame: all state clears immediately; the core receives no tlast for the partial frame (the core flags tlast_missing; accepted behaviour).

Test Plan:
- Release reset with tready_cfg=0 for 5 cycles then 1 -> config_tvalid high for 6 cycles, exactly one config handshake, tdata=16'h0A01, then RUN.
- NFFT_LOG2=3, continuous data_in 0..23, tready=1 -> 24 beats; tlast on beats with real=7, 15, 23; first tvalid two cycles after first write.
- data_in=14'h2000 with OFFSET_BIN=0 -> tdata=32'h0000E000. Same input with OFFSET_BIN=1 -> tdata=32'h00000000.
- FIFO_AW=2, tready=0 for 10 cycles with continuous input -> 4 FIFO words + 1 output register held, overflow=1, tdata stable. Then tready=1 -> the 5 held samples emerge in order.
- cfg_req at beat 3 of an 8-beat frame -> beats 4..7 emitted, tlast on beat 7, then a fresh config handshake, and the counter restarts at 0 on the next frame.
- Assert s_rst_n=0 mid-frame asynchronously -> all outputs 0 before the next sclk edge, busy_cfg=1.
